bank_miss_unit: RTL and testbench



---
 rtl/bank_miss_unit.sv | 193 +++++++++++++++++++
 tb/tb_bank_miss_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_miss_unit.sv
// bank_miss_unit: per-bank miss/writeback sequencer. It takes one tag-lookup
// result, issues the dirty-sector writebacks (offset 0 first) and any refill
// over a single valid/ready request channel, then reports completion.
// One transaction is in flight at a time.
module bank_miss_unit #(
  parameter int SET_W = 4,
  parameter int LSB_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             op_is_read_i,
  input  logic             op_is_write_i,
  input  logic             op_is_flush_i,
  input  logic             op_is_invalidate_i,
  input  logic             cacheline_hit_i,
  input  logic             cacheline_need_evit_i,
  input  logic [21:0]      evit_cacheline_tag_i,
  input  logic [21:0]      access_tag_i,
  input  logic [SET_W-1:0] access_set_i,
  input  logic             access_offset_i,
  input  logic [1:0]       offset0_state_i,
  input  logic [1:0]       offset1_state_i,
  input  logic [2:0]       access_way_i,

  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic             mem_req_write_o,
  output logic [31:0]      mem_req_addr_o,
  output logic [2:0]       mem_req_way_o,
  input  logic             mem_resp_valid_i,

  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [2:0]       done_way_o,
  output logic             done_refilled_o,
  output logic [1:0]       done_wb_cnt_o
);

  localparam logic [1:0] ST_INVALID = 2'b00;
  localparam logic [1:0] ST_DIRTY   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB0,
    S_WB0_WAIT,
    S_WB1,
    S_WB1_WAIT,
    S_RF,
    S_RF_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  // Captured transaction context.
  logic             need_wb1, need_rf;
  logic [21:0]      wb_tag, rf_tag;
  logic [SET_W-1:0] set_idx;
  logic             rf_offset;
  logic [2:0]       way;
  logic             refilled;
  logic [1:0]       wb_cnt;

  // Decode of the incoming lookup result. An illegal (non one-hot) opcode
  // falls through to a no-traffic completion.
  logic       op_legal, is_miss, wb_case, in_wb0, in_wb1, in_rf;
  logic [1:0] acc_state;
  logic       accept, resp_wb, resp_rf;

  assign op_legal  = $onehot({op_is_read_i, op_is_write_i, op_is_flush_i, op_is_invalidate_i});
  assign is_miss   = ~cacheline_hit_i;
  // Evictions happen only for read/write misses; a flush writes back a hit line.
  assign wb_case   = op_legal &
                     ((is_miss & cacheline_need_evit_i & (op_is_read_i | op_is_write_i)) |
                      (op_is_flush_i & cacheline_hit_i));
  assign in_wb0    = wb_case & (offset0_state_i == ST_DIRTY);
  assign in_wb1    = wb_case & (offset1_state_i == ST_DIRTY);
  assign acc_state = access_offset_i ? offset1_state_i : offset0_state_i;
  // Write misses overwrite the whole sector, so only reads refill.
  assign in_rf     = op_legal & op_is_read_i & (is_miss | (acc_state == ST_INVALID));

  assign accept  = req_valid_i & (state == S_IDLE);
  assign resp_wb = mem_resp_valid_i & ((state == S_WB0_WAIT) | (state == S_WB1_WAIT));
  assign resp_rf = mem_resp_valid_i & (state == S_RF_WAIT);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering; comb blocks use blocking (=).
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: walk WB0 -> WB1 -> RF -> DONE, skipping unneeded steps.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (in_wb0)      state_next = S_WB0;
          else if (in_wb1) state_next = S_WB1;
          else if (in_rf)  state_next = S_RF;
          else             state_next = S_DONE;
        end
      end
      S_WB0:      if (mem_req_ready_i) state_next = S_WB0_WAIT;
      S_WB0_WAIT: begin
        if (mem_resp_valid_i) begin
          if (need_wb1)     state_next = S_WB1;
          else if (need_rf) state_next = S_RF;
          else              state_next = S_DONE;
        end
      end
      S_WB1:      if (mem_req_ready_i) state_next = S_WB1_WAIT;
      S_WB1_WAIT: if (mem_resp_valid_i) state_next = need_rf ? S_RF : S_DONE;
      S_RF:       if (mem_req_ready_i) state_next = S_RF_WAIT;
      S_RF_WAIT:  if (mem_resp_valid_i) state_next = S_DONE;
      S_DONE:     if (done_ready_i) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Transaction context capture and completion counters.
  // The datapath is reset as well so every output shows a known value after rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      need_wb1  <= 1'b0;
      need_rf   <= 1'b0;
      wb_tag    <= '0;
      rf_tag    <= '0;
      set_idx   <= '0;
      rf_offset <= 1'b0;
      way       <= '0;
      refilled  <= 1'b0;
      wb_cnt    <= '0;
    end else if (accept) begin
      need_wb1  <= in_wb1;
      need_rf   <= in_rf;
      wb_tag    <= cacheline_hit_i ? access_tag_i : evit_cacheline_tag_i;
      rf_tag    <= access_tag_i;
      set_idx   <= access_set_i;
      rf_offset <= access_offset_i;
      way       <= access_way_i;
      refilled  <= 1'b0;
      wb_cnt    <= '0;
    end else begin
      if (resp_wb) wb_cnt   <= wb_cnt + 2'd1;
      if (resp_rf) refilled <= 1'b1;
    end
  end

  // Output decode: request fields come from state and captured registers only.
  always_comb begin
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_write_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_way_o   = '0;
    done_valid_o    = 1'b0;
    unique case (state)
      S_IDLE: req_ready_o = 1'b1;
      S_WB0: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
        mem_req_addr_o  = {wb_tag, set_idx, 1'b0, {LSB_W{1'b0}}};
        mem_req_way_o   = way;
      end
      S_WB1: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
        mem_req_addr_o  = {wb_tag, set_idx, 1'b1, {LSB_W{1'b0}}};
        mem_req_way_o   = way;
      end
      S_RF: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {rf_tag, set_idx, rf_offset, {LSB_W{1'b0}}};
        mem_req_way_o   = way;
      end
      S_DONE:  done_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign done_way_o      = way;
  assign done_refilled_o = refilled;
  assign done_wb_cnt_o   = wb_cnt;

endmodule

// File: tb/tb_bank_miss_unit.sv
// Testbench for bank_miss_unit: table of whole transactions with hand-computed
// request addresses and completion fields, plus stall and reset sequences.
module tb_bank_miss_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o;
  logic        op_is_read_i, op_is_write_i, op_is_flush_i, op_is_invalidate_i;
  logic        cacheline_hit_i, cacheline_need_evit_i;
  logic [21:0] evit_cacheline_tag_i, access_tag_i;
  logic [3:0]  access_set_i;
  logic        access_offset_i;
  logic [1:0]  offset0_state_i, offset1_state_i;
  logic [2:0]  access_way_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
  logic [31:0] mem_req_addr_o;
  logic [2:0]  mem_req_way_o;
  logic        mem_resp_valid_i;
  logic        done_valid_o, done_ready_i;
  logic [2:0]  done_way_o;
  logic        done_refilled_o;
  logic [1:0]  done_wb_cnt_o;

  bank_miss_unit #(.SET_W(4), .LSB_W(5)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .op_is_read_i          (op_is_read_i),
    .op_is_write_i         (op_is_write_i),
    .op_is_flush_i         (op_is_flush_i),
    .op_is_invalidate_i    (op_is_invalidate_i),
    .cacheline_hit_i       (cacheline_hit_i),
    .cacheline_need_evit_i (cacheline_need_evit_i),
    .evit_cacheline_tag_i  (evit_cacheline_tag_i),
    .access_tag_i          (access_tag_i),
    .access_set_i          (access_set_i),
    .access_offset_i       (access_offset_i),
    .offset0_state_i       (offset0_state_i),
    .offset1_state_i       (offset1_state_i),
    .access_way_i          (access_way_i),
    .mem_req_valid_o       (mem_req_valid_o),
    .mem_req_ready_i       (mem_req_ready_i),
    .mem_req_write_o       (mem_req_write_o),
    .mem_req_addr_o        (mem_req_addr_o),
    .mem_req_way_o         (mem_req_way_o),
    .mem_resp_valid_i      (mem_resp_valid_i),
    .done_valid_o          (done_valid_o),
    .done_ready_i          (done_ready_i),
    .done_way_o            (done_way_o),
    .done_refilled_o       (done_refilled_o),
    .done_wb_cnt_o         (done_wb_cnt_o)
  );

  always #5 clk = ~clk;

  // One transaction: lookup inputs plus the expected request list and completion.
  typedef struct {
    logic [3:0]       op;     // {invalidate, flush, write, read}
    logic             hit;
    logic             evit;
    logic [21:0]      etag;
    logic [21:0]      atag;
    logic [3:0]       set;
    logic             off;
    logic [1:0]       s0;
    logic [1:0]       s1;
    logic [2:0]       way;
    int               n_req;
    logic [2:0][31:0] addr;   // addr[0] is the first request
    logic [2:0]       wr;     // wr[0] is the first request
    logic             refilled;
    logic [1:0]       wb_cnt;
  } vec_t;

  localparam int N_VEC = 11;
  vec_t vecs [N_VEC];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  // Counts request-channel handshakes so extra or missing requests show up.
  always @(posedge clk) if (mem_req_valid_o && mem_req_ready_i) hs_cnt <= hs_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    op_is_read_i          = v.op[0];
    op_is_write_i         = v.op[1];
    op_is_flush_i         = v.op[2];
    op_is_invalidate_i    = v.op[3];
    cacheline_hit_i       = v.hit;
    cacheline_need_evit_i = v.evit;
    evit_cacheline_tag_i  = v.etag;
    access_tag_i          = v.atag;
    access_set_i          = v.set;
    access_offset_i       = v.off;
    offset0_state_i       = v.s0;
    offset1_state_i       = v.s1;
    access_way_i          = v.way;
  endtask

  // Inputs are scrambled after acceptance so the unit must work from its capture.
  task automatic scramble();
    op_is_read_i          = 1'($urandom);
    op_is_write_i         = 1'($urandom);
    op_is_flush_i         = 1'($urandom);
    op_is_invalidate_i    = 1'($urandom);
    cacheline_hit_i       = 1'($urandom);
    cacheline_need_evit_i = 1'($urandom);
    evit_cacheline_tag_i  = 22'($urandom);
    access_tag_i          = 22'($urandom);
    access_set_i          = 4'($urandom);
    access_offset_i       = 1'($urandom);
    offset0_state_i       = 2'($urandom);
    offset1_state_i       = 2'($urandom);
    access_way_i          = 3'($urandom);
  endtask

  task automatic accept_vec(input string name, input vec_t v);
    apply(v);
    req_valid_i = 1'b1;
    check({name, " ready_before"}, 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    scramble();
  endtask

  // Expects a request to be presented now; accepts it and returns one response.
  task automatic serve(input string name, input logic [31:0] addr, input logic wr, input logic [2:0] way);
    check({name, " req_valid"}, 32'(mem_req_valid_o), 32'd1);
    check({name, " req_addr"},  mem_req_addr_o,        addr);
    check({name, " req_write"}, 32'(mem_req_write_o),  32'(wr));
    check({name, " req_way"},   32'(mem_req_way_o),    32'(way));
    check({name, " busy"},      32'(req_ready_o),      32'd0);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    check({name, " wait_no_req"}, 32'(mem_req_valid_o), 32'd0);
    mem_resp_valid_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b0;
  endtask

  task automatic check_done(input string name, input vec_t v);
    check({name, " done_valid"},    32'(done_valid_o),    32'd1);
    check({name, " done_way"},      32'(done_way_o),      32'(v.way));
    check({name, " done_refilled"}, 32'(done_refilled_o), 32'(v.refilled));
    check({name, " done_wb_cnt"},   32'(done_wb_cnt_o),   32'(v.wb_cnt));
    check({name, " no_req"},        32'(mem_req_valid_o), 32'd0);
    check({name, " busy"},          32'(req_ready_o),     32'd0);
  endtask

  task automatic finish_done(input string name);
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    check({name, " ready_after"}, 32'(req_ready_o),  32'd1);
    check({name, " done_clear"},  32'(done_valid_o), 32'd0);
  endtask

  task automatic run_vec(input int idx);
    vec_t  v;
    string name;
    int    hs0;
    v    = vecs[idx];
    name = $sformatf("v%0d", idx);
    accept_vec(name, v);
    hs0 = hs_cnt;
    for (int r = 0; r < v.n_req; r++)
      serve($sformatf("%s r%0d", name, r), v.addr[r], v.wr[r], v.way);
    check_done(name, v);
    check({name, " handshakes"}, 32'(hs_cnt - hs0), 32'(v.n_req));
    finish_done(name);
  endtask

  task automatic check_reset(input string name);
    check({name, " req_ready"},     32'(req_ready_o),     32'd1);
    check({name, " mem_req_valid"}, 32'(mem_req_valid_o), 32'd0);
    check({name, " mem_req_write"}, 32'(mem_req_write_o), 32'd0);
    check({name, " mem_req_addr"},  mem_req_addr_o,       32'd0);
    check({name, " mem_req_way"},   32'(mem_req_way_o),   32'd0);
    check({name, " done_valid"},    32'(done_valid_o),    32'd0);
    check({name, " done_way"},      32'(done_way_o),      32'd0);
    check({name, " done_refilled"}, 32'(done_refilled_o), 32'd0);
    check({name, " done_wb_cnt"},   32'(done_wb_cnt_o),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // Addresses are {tag[21:0], set[3:0], offset, 5'b0}.
    // read hit, clean: no traffic
    vecs[0]  = '{op:4'b0001, hit:1, evit:0, etag:22'h0, atag:22'h00555, set:4'd0, off:0,
                 s0:2'b01, s1:2'b01, way:3'd5, n_req:0, addr:{32'h0, 32'h0, 32'h0},
                 wr:3'b000, refilled:0, wb_cnt:2'd0};
    // read miss, both sectors dirty: two writebacks then refill
    vecs[1]  = '{op:4'b0001, hit:0, evit:1, etag:22'h12345, atag:22'h0ABCD, set:4'd3, off:1,
                 s0:2'b10, s1:2'b10, way:3'd2, n_req:3,
                 addr:{32'h02AF34E0, 32'h048D14E0, 32'h048D14C0},
                 wr:3'b011, refilled:1, wb_cnt:2'd2};
    // read hit, accessed sector 1 invalid: single refill, dirty sector 0 untouched
    vecs[2]  = '{op:4'b0001, hit:1, evit:1, etag:22'h3, atag:22'h000001, set:4'd0, off:1,
                 s0:2'b10, s1:2'b00, way:3'd7, n_req:1, addr:{32'h0, 32'h0, 32'h00000420},
                 wr:3'b000, refilled:1, wb_cnt:2'd0};
    // flush hit, sector 1 dirty: one writeback with access tag
    vecs[3]  = '{op:4'b0100, hit:1, evit:0, etag:22'h1, atag:22'h3FFFFF, set:4'd15, off:0,
                 s0:2'b01, s1:2'b10, way:3'd1, n_req:1, addr:{32'h0, 32'h0, 32'hFFFFFFE0},
                 wr:3'b001, refilled:0, wb_cnt:2'd1};
    // write miss with eviction: writeback only, no refill
    vecs[4]  = '{op:4'b0010, hit:0, evit:1, etag:22'h000ABC, atag:22'h111111, set:4'd5, off:1,
                 s0:2'b10, s1:2'b00, way:3'd4, n_req:1, addr:{32'h0, 32'h0, 32'h002AF140},
                 wr:3'b001, refilled:0, wb_cnt:2'd1};
    // invalidate hit with dirty sectors: no traffic
    vecs[5]  = '{op:4'b1000, hit:1, evit:1, etag:22'h7, atag:22'h9, set:4'd6, off:0,
                 s0:2'b10, s1:2'b10, way:3'd6, n_req:0, addr:{32'h0, 32'h0, 32'h0},
                 wr:3'b000, refilled:0, wb_cnt:2'd0};
    // flush miss: no traffic
    vecs[6]  = '{op:4'b0100, hit:0, evit:1, etag:22'h7, atag:22'h9, set:4'd6, off:1,
                 s0:2'b10, s1:2'b10, way:3'd0, n_req:0, addr:{32'h0, 32'h0, 32'h0},
                 wr:3'b000, refilled:0, wb_cnt:2'd0};
    // illegal opcode (read+write) on an evicting miss: no traffic
    vecs[7]  = '{op:4'b0011, hit:0, evit:1, etag:22'h7, atag:22'h9, set:4'd6, off:1,
                 s0:2'b10, s1:2'b10, way:3'd3, n_req:0, addr:{32'h0, 32'h0, 32'h0},
                 wr:3'b000, refilled:0, wb_cnt:2'd0};
    // read miss, no eviction needed: refill only
    vecs[8]  = '{op:4'b0001, hit:0, evit:0, etag:22'h7, atag:22'h000002, set:4'd2, off:0,
                 s0:2'b10, s1:2'b10, way:3'd2, n_req:1, addr:{32'h0, 32'h0, 32'h00000880},
                 wr:3'b000, refilled:1, wb_cnt:2'd0};
    // write hit on invalid sector: no refill, no traffic
    vecs[9]  = '{op:4'b0010, hit:1, evit:0, etag:22'h7, atag:22'h9, set:4'd9, off:0,
                 s0:2'b00, s1:2'b00, way:3'd1, n_req:0, addr:{32'h0, 32'h0, 32'h0},
                 wr:3'b000, refilled:0, wb_cnt:2'd0};
    // read miss, only sector 1 dirty: WB1 then refill
    vecs[10] = '{op:4'b0001, hit:0, evit:1, etag:22'h3FFFFF, atag:22'h000000, set:4'd1, off:0,
                 s0:2'b00, s1:2'b10, way:3'd0, n_req:2,
                 addr:{32'h0, 32'h00000040, 32'hFFFFFC60},
                 wr:3'b001, refilled:1, wb_cnt:2'd1};

    rst_i = 1'b1;
    req_valid_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    done_ready_i = 1'b0;
    apply(vecs[0]);
    repeat (3) tick();
    rst_i = 1'b0;
    check_reset("reset");

    for (int i = 0; i < N_VEC; i++) run_vec(i);

    // Stalled request channel, stray and same-cycle responses, stalled completion.
    v = vecs[1];
    accept_vec("stall", v);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stall c%0d req_valid", c), 32'(mem_req_valid_o), 32'd1);
      check($sformatf("stall c%0d req_addr", c),  mem_req_addr_o,       v.addr[0]);
      check($sformatf("stall c%0d req_write", c), 32'(mem_req_write_o), 32'd1);
      check($sformatf("stall c%0d req_way", c),   32'(mem_req_way_o),   32'(v.way));
      check($sformatf("stall c%0d busy", c),      32'(req_ready_o),     32'd0);
      mem_resp_valid_i = (c == 4);
      tick();
    end
    mem_resp_valid_i = 1'b0;
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b1;
    tick();
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    check("stall same_cycle_resp wait0", 32'(mem_req_valid_o), 32'd0);
    tick();
    check("stall same_cycle_resp wait1", 32'(mem_req_valid_o), 32'd0);
    check("stall same_cycle_resp wb_cnt", 32'(done_wb_cnt_o), 32'd0);
    mem_resp_valid_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b0;
    serve("stall r1", v.addr[1], v.wr[1], v.way);
    serve("stall r2", v.addr[2], v.wr[2], v.way);
    for (int c = 0; c < 5; c++) begin
      check_done($sformatf("stall d%0d", c), v);
      tick();
    end
    finish_done("stall");

    // Reset while waiting for the second writeback response, then a late response.
    v = vecs[1];
    accept_vec("rst", v);
    serve("rst r0", v.addr[0], v.wr[0], v.way);
    check("rst wb1 valid", 32'(mem_req_valid_o), 32'd1);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    check("rst wb_cnt before", 32'(done_wb_cnt_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset("rst mid");
    mem_resp_valid_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b0;
    check_reset("rst stray");
    tick();
    check_reset("rst idle");

    run_vec(3);
    run_vec(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
